// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral slave among N_MASTERS initiators, one outstanding transaction.
// Optional response watchdog: define PERIPH_ARB_TIMEOUT_EN.
module periph_bus_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int ID_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_MASTERS-1:0]                mst_req_i,
    input  logic [N_MASTERS-1:0][31:0]          mst_add_i,
    input  logic [N_MASTERS-1:0]                mst_wen_i,
    input  logic [N_MASTERS-1:0][31:0]          mst_wdata_i,
    input  logic [N_MASTERS-1:0][3:0]           mst_be_i,
    input  logic [N_MASTERS-1:0][ID_WIDTH-1:0]  mst_id_i,
    output logic [N_MASTERS-1:0]                mst_gnt_o,
    output logic [N_MASTERS-1:0]                mst_r_valid_o,
    output logic [31:0]                         mst_r_rdata_o,
    output logic [ID_WIDTH-1:0]                 mst_r_id_o,
    output logic                                mst_r_opc_o,
    output logic                                slv_req_o,
    output logic [31:0]                         slv_add_o,
    output logic                                slv_wen_o,
    output logic [31:0]                         slv_wdata_o,
    output logic [3:0]                          slv_be_o,
    output logic [ID_WIDTH-1:0]                 slv_id_o,
    input  logic                                slv_gnt_i,
    input  logic                                slv_r_valid_i,
    input  logic [31:0]                         slv_r_rdata_i,
    input  logic [ID_WIDTH-1:0]                 slv_r_id_i,
    input  logic                                slv_r_opc_i
);
    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [IW-1:0]  rr_ptr, owner, lock_idx, sel;
    logic           locked, any_req, grant, rsp_fire, to_fire;

    // A locked selection is held even when a higher-priority initiator shows up.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        if (locked) begin
            sel     = lock_idx;
            any_req = mst_req_i[lock_idx];
        end else begin
            for (int i = N_MASTERS-1; i >= 0; i--) begin
                if (mst_req_i[(int'(rr_ptr) + i) % N_MASTERS]) begin
                    sel     = IW'((int'(rr_ptr) + i) % N_MASTERS);
                    any_req = 1'b1;
                end
            end
        end
    end

    assign slv_req_o   = (state == IDLE) && any_req;
    assign grant       = slv_req_o && slv_gnt_i;
    assign mst_gnt_o   = grant ? (N_MASTERS'(1) << sel) : '0;

    assign slv_add_o   = slv_req_o ? mst_add_i[sel]   : mst_add_i[0];
    assign slv_wen_o   = slv_req_o ? mst_wen_i[sel]   : mst_wen_i[0];
    assign slv_wdata_o = slv_req_o ? mst_wdata_i[sel] : mst_wdata_i[0];
    assign slv_be_o    = slv_req_o ? mst_be_i[sel]    : mst_be_i[0];
    assign slv_id_o    = slv_req_o ? mst_id_i[sel]    : mst_id_i[0];

    assign rsp_fire    = (state == BUSY) && slv_r_valid_i;

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]       wd_cnt;
    logic [ID_WIDTH-1:0] stored_id;

    // A real response in the limit cycle takes precedence over the timeout.
    assign to_fire    = (state == BUSY) && !slv_r_valid_i && (wd_cnt == CW'(TIMEOUT_CYCLES));
    assign mst_r_id_o = rsp_fire ? slv_r_id_i : (to_fire ? stored_id : '0);
`else
    // Watchdog compiled out; the comparison is constant false.
    assign to_fire    = (TIMEOUT_CYCLES < 0);
    assign mst_r_id_o = rsp_fire ? slv_r_id_i : '0;
`endif

    assign mst_r_valid_o = (rsp_fire || to_fire) ? (N_MASTERS'(1) << owner) : '0;
    assign mst_r_rdata_o = rsp_fire ? slv_r_rdata_i : '0;
    assign mst_r_opc_o   = rsp_fire ? slv_r_opc_i : to_fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
`ifdef PERIPH_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
            stored_id <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner  <= sel;
                        rr_ptr <= (sel == IW'(N_MASTERS-1)) ? '0 : sel + 1'b1;
                        locked <= 1'b0;
                        state  <= BUSY;
`ifdef PERIPH_ARB_TIMEOUT_EN
                        wd_cnt    <= '0;
                        stored_id <= mst_id_i[sel];
`endif
                    end else if (slv_req_o) begin
                        locked   <= 1'b1;
                        lock_idx <= sel;
                    end else begin
                        // Covers an initiator dropping its request while locked.
                        locked <= 1'b0;
                    end
                end
                BUSY: begin
                    if (rsp_fire || to_fire) begin
                        state <= IDLE;
                    end
`ifdef PERIPH_ARB_TIMEOUT_EN
                    else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
